fetch_unit: RTL

- RV32I instruction fetch stage.
- Generates sequential PCs and issues in-order requests to instruction memory over a valid/ready request channel.
- Buffers returned instructions in a small prefetch FIFO and presents {pc, instr} to the decode/control stage with a valid/ready handshake.
- Accepts PC redirects from the branch/jump resolution logic, flushes the FIFO and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr}; flush wins over push, head reads zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: credit-limited in-order imem requests, prefetch FIFO,
// redirect flush with stale-response dropping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);
  localparam int CW = $clog2(DEPTH + 1) + 1;

  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]   inflight, drop, fifo_count, credit;
  logic            run, req_hs, push, pop, fifo_empty, fifo_full;
  fetch_entry_t    head;

  // Live entries = buffered + in flight minus those already doomed to be dropped.
  assign credit         = fifo_count + inflight - drop;
  assign imem_req_valid = run && !redirect_valid && (credit < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && !redirect_valid && (drop == '0);
  assign if_valid       = !fifo_empty && !redirect_valid;
  assign pop            = if_valid && if_ready;
  assign if_pc          = head.pc;
  assign if_instr       = head.instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      run      <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= inflight + CW'(req_hs) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
        drop     <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (req_hs) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (imem_rsp_valid) begin
          if (drop != '0) drop   <= drop - 1'b1;
          else            rsp_pc <= rsp_pc + XLEN'(PC_STEP);
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ('{pc: rsp_pc, instr: imem_rsp_data}),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));
endmodule
